ibex_fp_issue_ctrl: RTL

IBEX_FP_ISSUE_CTRL -- requirements
Module: ibex_fp_issue_ctrl

---
 rtl/ibex_pkg.sv | 61 ++++++
 rtl/ibex_fcsr.sv | 94 +++++++++
 rtl/ibex_fp_issue_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the FP issue controller: ISA encodings, CSR addresses,
// FP rounding modes and the FPU exception-flag layout.
package ibex_pkg;

    typedef enum logic [1:0] {
        RV32FNone   = 2'd0,
        RV32FSingle = 2'd1,
        RV64FDouble = 2'd2
    } rvfloat_e;

    typedef enum logic [6:0] {
        OPCODE_LOAD_FP  = 7'h07,
        OPCODE_STORE_FP = 7'h27,
        OPCODE_MADD     = 7'h43,
        OPCODE_MSUB     = 7'h47,
        OPCODE_NMSUB    = 7'h4b,
        OPCODE_NMADD    = 7'h4f,
        OPCODE_OP_FP    = 7'h53
    } opcode_e;

    typedef enum logic {
        FP32 = 1'b0,
        FP64 = 1'b1
    } fp_type_e;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } fp_rm_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_status_t;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    function automatic int unsigned fpu_width(input rvfloat_e cfg);
        case (cfg)
            RV64FDouble: return 32'd64;
            default:     return 32'd32;
        endcase
    endfunction

endpackage

// File: rtl/ibex_fcsr.sv
// Floating-point CSR file: fflags/frm storage, CSR address decode and the
// read-modify-write path, merged with FPU exception-flag accumulation.
module ibex_fcsr
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_access_i,
    input  logic [11:0] csr_addr_i,
    input  csr_op_e     csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        status_we_i,
    input  fp_status_t  status_i,
    output logic [2:0]  frm_o
);

    logic [4:0]  fflags_r;
    logic [2:0]  frm_r;
    logic [4:0]  fflags_next_s;
    logic [2:0]  frm_next_s;
    logic [31:0] old_s;
    logic [31:0] result_s;
    logic        legal_s;
    logic        write_s;
    logic        unused_s;

    // Address decode: current value of the selected CSR, zero-extended.
    always_comb begin
        old_s   = 32'h0000_0000;
        legal_s = 1'b1;
        case (csr_addr_i)
            CSR_FFLAGS: old_s = {27'h000_0000, fflags_r};
            CSR_FRM:    old_s = {29'h0000_0000, frm_r};
            CSR_FCSR:   old_s = {24'h00_0000, frm_r, fflags_r};
            default:    legal_s = 1'b0;
        endcase
    end

    // CSR operation applied to the old value.
    always_comb begin
        case (csr_op_i)
            CSR_OP_READ:  result_s = old_s;
            CSR_OP_WRITE: result_s = csr_wdata_i;
            CSR_OP_SET:   result_s = old_s | csr_wdata_i;
            CSR_OP_CLEAR: result_s = old_s & ~csr_wdata_i;
            default:      result_s = old_s;
        endcase
    end

    assign write_s = csr_access_i & legal_s & (csr_op_i != CSR_OP_READ);

    // Next-state: CSR update first, then FPU flags OR-ed on top so a same-cycle
    // completion is never lost.
    always_comb begin
        fflags_next_s = fflags_r;
        frm_next_s    = frm_r;
        if (write_s && (csr_addr_i == CSR_FFLAGS || csr_addr_i == CSR_FCSR)) begin
            fflags_next_s = result_s[4:0];
        end else begin
            fflags_next_s = fflags_r;
        end
        if (status_we_i) begin
            fflags_next_s = fflags_next_s | status_i;
        end else begin
            fflags_next_s = fflags_next_s;
        end
        if (write_s && csr_addr_i == CSR_FCSR) begin
            frm_next_s = result_s[7:5];
        end else if (write_s && csr_addr_i == CSR_FRM) begin
            frm_next_s = result_s[2:0];
        end else begin
            frm_next_s = frm_r;
        end
    end

    // CSR storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_r <= 5'b00000;
            frm_r    <= RNE;
        end else begin
            fflags_r <= fflags_next_s;
            frm_r    <= frm_next_s;
        end
    end

    assign csr_rdata_o   = old_s;
    assign csr_illegal_o = csr_access_i & ~legal_s;
    assign frm_o         = frm_r;
    assign unused_s      = ^result_s[31:8];

endmodule

// File: rtl/ibex_fp_issue_ctrl.sv
// FP instruction issue controller: resolves the rounding mode, issues to the FPU,
// collects the result for writeback and handles flush/drain of in-flight work.
module ibex_fp_issue_ctrl
    import ibex_pkg::*;
#(
    parameter rvfloat_e RVFloat = RV32FSingle
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              fp_req_i,
    input  opcode_e                           fp_opcode_i,
    input  fp_type_e                          fp_fmt_i,
    input  logic [2:0]                        fp_rm_i,
    output logic                              fp_busy_o,
    output logic                              fp_illegal_o,
    output logic                              fpu_in_valid_o,
    input  logic                              fpu_in_ready_i,
    output logic [2:0]                        fpu_rm_o,
    input  logic                              fpu_out_valid_i,
    output logic                              fpu_out_ready_o,
    input  logic [fpu_width(RVFloat)-1:0]     fpu_result_i,
    input  fp_status_t                        fpu_status_i,
    output logic                              fp_wb_valid_o,
    output logic [fpu_width(RVFloat)-1:0]     fp_wb_data_o,
    input  logic                              flush_i,
    input  logic                              csr_access_i,
    input  logic [11:0]                       csr_addr_i,
    input  csr_op_e                           csr_op_i,
    input  logic [31:0]                       csr_wdata_i,
    output logic [31:0]                       csr_rdata_o,
    output logic                              csr_illegal_o
);

    localparam int unsigned FLEN = fpu_width(RVFloat);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } fsm_state_e;

    fsm_state_e      state_r;
    logic [2:0]      rm_r;
    opcode_e         opcode_r;
    fp_type_e        fmt_r;
    logic            busy_r;
    logic            illegal_r;
    logic            in_valid_r;
    logic            out_ready_r;
    logic            wb_valid_r;
    logic [FLEN-1:0] wb_data_r;
    logic [2:0]      frm_s;
    logic [2:0]      rm_resolved_s;
    logic            rm_illegal_s;
    logic            status_we_s;
    logic            unused_s;

    assign rm_resolved_s = (fp_rm_i == DYN) ? frm_s : fp_rm_i;
    assign rm_illegal_s  = rm_resolved_s inside {3'b101, 3'b110, 3'b111};
    assign status_we_s   = (state_r == WAIT) & fpu_out_valid_i & ~flush_i;

    ibex_fcsr u_fcsr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .csr_access_i  (csr_access_i),
        .csr_addr_i    (csr_addr_i),
        .csr_op_i      (csr_op_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .status_we_i   (status_we_s),
        .status_i      (fpu_status_i),
        .frm_o         (frm_s)
    );

    // Issue FSM with registered handshake outputs; rm is latched at acceptance so
    // later frm writes cannot disturb the in-flight instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            rm_r        <= 3'b000;
            opcode_r    <= OPCODE_OP_FP;
            fmt_r       <= FP32;
            busy_r      <= 1'b0;
            illegal_r   <= 1'b0;
            in_valid_r  <= 1'b0;
            out_ready_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_data_r   <= '0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fp_req_i && rm_illegal_s) begin
                        illegal_r <= 1'b1;
                    end else if (fp_req_i) begin
                        rm_r       <= rm_resolved_s;
                        opcode_r   <= fp_opcode_i;
                        fmt_r      <= fp_fmt_i;
                        busy_r     <= 1'b1;
                        in_valid_r <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    // An accepted transfer cannot be recalled; a flush then drains it.
                    if (fpu_in_ready_i) begin
                        in_valid_r  <= 1'b0;
                        out_ready_r <= 1'b1;
                        state_r     <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        in_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    if (fpu_out_valid_i && flush_i) begin
                        out_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else if (fpu_out_valid_i) begin
                        out_ready_r <= 1'b0;
                        wb_valid_r  <= 1'b1;
                        wb_data_r   <= fpu_result_i;
                        state_r     <= DONE;
                    end else if (flush_i) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DRAIN: begin
                    if (fpu_out_valid_i) begin
                        out_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    wb_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy_r      <= 1'b0;
                    in_valid_r  <= 1'b0;
                    out_ready_r <= 1'b0;
                    wb_valid_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign fp_busy_o       = busy_r;
    assign fp_illegal_o    = illegal_r;
    assign fpu_in_valid_o  = in_valid_r;
    assign fpu_rm_o        = rm_r;
    assign fpu_out_ready_o = out_ready_r;
    assign fp_wb_valid_o   = wb_valid_r & ~flush_i;
    assign fp_wb_data_o    = wb_data_r;
    assign unused_s        = ^{opcode_r, fmt_r};

endmodule
